// File: rtl/fp8_pkg.sv
// -----------------------------------------------------------------------------
// fp8_pkg
// Shared definitions for the E4M3 (1|4|3, bias 7) to IEEE-754 float32 decode
// path: format constants, the float32 quiet-NaN payload, the exponent
// re-bias offset and the decoded-result struct used between the lane decoder
// and the streaming wrapper.
// -----------------------------------------------------------------------------
package fp8_pkg;

   localparam int unsigned E4M3_BIAS  = 7;
   localparam int unsigned E4M3_EXP_W = 4;
   localparam int unsigned E4M3_MAN_W = 3;
   localparam int unsigned F32_BIAS   = 127;

   localparam logic [22:0] F32_QNAN_MAN = 23'h400000;

   // Re-bias from E4M3 to float32: 127 - 7 = 120.
   localparam logic [7:0]  EXP_OFFSET = 8'(F32_BIAS - E4M3_BIAS);

   typedef struct packed {
      logic [31:0] data;
      logic        nan;
      logic        inf;
   } fp8_dec_t;

endpackage

// File: rtl/fp8_e4m3_unpack.sv
// -----------------------------------------------------------------------------
// fp8_e4m3_unpack
// Purely combinational decode of one E4M3 byte into float32 bits plus NaN/Inf
// flags. Every E4M3 value is exactly representable in float32, so no rounding
// is involved; subnormals are renormalized by locating the leading one.
//
// Ports:
//   i_byte  in   8   E4M3 byte {sign, exp[3:0], man[2:0]}
//   o_dec   out  fp8_dec_t  {float32 bits, nan flag, inf flag}
// -----------------------------------------------------------------------------
module fp8_e4m3_unpack
   import fp8_pkg::*;
(
   input  logic [7:0] i_byte,
   output fp8_dec_t   o_dec
);

   logic                  w_sign;
   logic [E4M3_EXP_W-1:0] w_exp;
   logic [E4M3_MAN_W-1:0] w_man;

   assign w_sign = i_byte[7];
   assign w_exp  = i_byte[E4M3_MAN_W +: E4M3_EXP_W];
   assign w_man  = i_byte[0 +: E4M3_MAN_W];

   always_comb begin
      // NOTE: default every output first so no path through the branches can infer a latch.
      o_dec = '0;
      if (w_exp == '1) begin
         if (w_man == '0) begin
            o_dec.data = {w_sign, 8'hFF, 23'h0};
            o_dec.inf  = 1'b1;
         end else begin
            // Quiet NaN with the sign kept; the E4M3 payload is not preserved.
            o_dec.data = {w_sign, 8'hFF, F32_QNAN_MAN};
            o_dec.nan  = 1'b1;
         end
      end else if (w_exp != '0) begin
         o_dec.data = {w_sign, EXP_OFFSET + {4'b0, w_exp}, w_man, 20'b0};
      end else if (w_man == '0) begin
         o_dec.data = {w_sign, 31'b0};
      end else begin
         // Subnormal m * 2^-9: shift the leading one into the hidden bit.
         // The exponent falls by one for every leading zero of m.
         casez (w_man)
            3'b001:  o_dec.data = {w_sign, EXP_OFFSET - 8'd2, 23'b0};
            3'b01?:  o_dec.data = {w_sign, EXP_OFFSET - 8'd1, w_man[0], 22'b0};
            default: o_dec.data = {w_sign, EXP_OFFSET, w_man[1:0], 21'b0};
         endcase
      end
   end

endmodule

// File: rtl/fp8_e4m3_unpack_stream.sv
// -----------------------------------------------------------------------------
// fp8_e4m3_unpack_stream
// Streaming E4M3 -> float32 decoder. Accepts LANES-byte words on a
// valid/ready input, buffers one word and serializes it lane by lane through
// a single lane decoder into a registered valid/ready output, one float32 per
// cycle. The next word is accepted in the same cycle the last lane advances,
// so back-to-back words stream without a bubble. Saturating counters track
// NaN and Inf beats handed off downstream.
//
// Ports:
//   clk_i        in   1            clock
//   rst_ni       in   1            synchronous active-low reset
//   in_data_i    in   8*LANES      packed word, lane k = bits [8k+7:8k]
//   in_last_i    in   1            word is the last of a tile
//   in_valid_i   in   1            input word valid
//   in_ready_o   out  1            input word accepted when valid & ready
//   out_data_o   out  32           float32 bits
//   out_lane_o   out  clog2(LANES) source lane of the current beat
//   out_nan_o    out  1            current beat is NaN
//   out_inf_o    out  1            current beat is +/-Inf
//   out_last_o   out  1            last lane of a word marked last
//   out_valid_o  out  1            output beat valid
//   out_ready_i  in   1            downstream ready
//   clr_cnt_i    in   1            synchronous counter clear
//   nan_cnt_o    out  CNT_W        saturating NaN beat count
//   inf_cnt_o    out  CNT_W        saturating Inf beat count
//
// LANES must be at least 2.
// -----------------------------------------------------------------------------
module fp8_e4m3_unpack_stream
   import fp8_pkg::*;
#(
   parameter int LANES = 4,
   parameter int CNT_W = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [8*LANES-1:0]       in_data_i,
   input  logic                     in_last_i,
   input  logic                     in_valid_i,
   output logic                     in_ready_o,
   output logic [31:0]              out_data_o,
   output logic [$clog2(LANES)-1:0] out_lane_o,
   output logic                     out_nan_o,
   output logic                     out_inf_o,
   output logic                     out_last_o,
   output logic                     out_valid_o,
   input  logic                     out_ready_i,
   input  logic                     clr_cnt_i,
   output logic [CNT_W-1:0]         nan_cnt_o,
   output logic [CNT_W-1:0]         inf_cnt_o
);

   localparam int            LW        = $clog2(LANES);
   localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);

   // Word buffer and drain state
   logic                 r_busy;
   logic [LW-1:0]        r_lane;
   logic [8*LANES-1:0]   r_buf;
   logic                 r_last;

   // Registered output beat
   logic [31:0]          r_out_data;
   logic [LW-1:0]        r_out_lane;
   logic                 r_out_nan;
   logic                 r_out_inf;
   logic                 r_out_last;
   logic                 r_out_valid;

   logic [CNT_W-1:0]     r_nan_cnt;
   logic [CNT_W-1:0]     r_inf_cnt;

   logic                 w_adv;
   logic                 w_at_last;
   logic                 w_in_ready;
   logic                 w_in_fire;
   logic                 w_out_fire;
   logic [7:0]           w_lane_byte;
   fp8_dec_t             w_dec;

   // The output register may take a new beat when it is empty or being
   // drained this cycle. Ready depends only on state and out_ready_i.
   assign w_adv      = r_busy & (~r_out_valid | out_ready_i);
   assign w_at_last  = (r_lane == LAST_LANE);
   assign w_in_ready = rst_ni & (~r_busy | (w_adv & w_at_last));
   assign w_in_fire  = in_valid_i & w_in_ready;
   assign w_out_fire = r_out_valid & out_ready_i;

   assign w_lane_byte = r_buf[{r_lane, 3'b000} +: 8];

   fp8_e4m3_unpack u_unpack (
      .i_byte (w_lane_byte),
      .o_dec  (w_dec)
   );

   // NOTE: the word buffer is pure datapath; it is only read while r_busy is set, so it needs no reset.
   always_ff @(posedge clk_i) begin
      if (w_in_fire) begin
         r_buf <= in_data_i;
      end
   end

   // NOTE: sequential state uses non-blocking assignments and a reset sampled on the clock edge.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         r_busy      <= 1'b0;
         r_lane      <= '0;
         r_last      <= 1'b0;
         r_out_data  <= '0;
         r_out_lane  <= '0;
         r_out_nan   <= 1'b0;
         r_out_inf   <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         if (w_adv) begin
            r_out_data  <= w_dec.data;
            r_out_nan   <= w_dec.nan;
            r_out_inf   <= w_dec.inf;
            r_out_lane  <= r_lane;
            r_out_last  <= r_last & w_at_last;
            r_out_valid <= 1'b1;
            if (!w_at_last) begin
               r_lane <= r_lane + LW'(1);
            end else begin
               r_busy <= w_in_fire;
            end
         end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
         end
         // A new word can only arrive when idle or on the final lane's
         // advance, so this overrides the lane/busy update above.
         if (w_in_fire) begin
            r_last <= in_last_i;
            r_lane <= '0;
            r_busy <= 1'b1;
         end
      end
   end

   // Debug counters: clear wins over a same-cycle increment; hold at all-ones.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || clr_cnt_i) begin
         r_nan_cnt <= '0;
         r_inf_cnt <= '0;
      end else begin
         if (w_out_fire && r_out_nan && !(&r_nan_cnt)) begin
            r_nan_cnt <= r_nan_cnt + CNT_W'(1);
         end
         if (w_out_fire && r_out_inf && !(&r_inf_cnt)) begin
            r_inf_cnt <= r_inf_cnt + CNT_W'(1);
         end
      end
   end

   assign in_ready_o  = w_in_ready;
   assign out_data_o  = r_out_data;
   assign out_lane_o  = r_out_lane;
   assign out_nan_o   = r_out_nan;
   assign out_inf_o   = r_out_inf;
   assign out_last_o  = r_out_last;
   assign out_valid_o = r_out_valid;
   assign nan_cnt_o   = r_nan_cnt;
   assign inf_cnt_o   = r_inf_cnt;

endmodule

// File: tb/tb_fp8_e4m3_unpack_stream.sv
// -----------------------------------------------------------------------------
// tb_fp8_e4m3_unpack_stream
// Directed plus random stimulus for fp8_e4m3_unpack_stream. Two instances
// share all inputs: one with 16-bit counters, one with 4-bit counters to
// reach saturation quickly. Expected beats come from a value-level model
// (E4M3 value computed as a real, then re-encoded to float32 bits) held in a
// queue; expected counter values come from a saturating integer model.
// -----------------------------------------------------------------------------
module tb_fp8_e4m3_unpack_stream;

   localparam int LANES = 4;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [31:0] in_data;
   logic        in_last;
   logic        in_valid;
   logic        out_ready;
   logic        clr;

   logic        in_ready;
   logic [31:0] out_data;
   logic [1:0]  out_lane;
   logic        out_nan, out_inf, out_last, out_valid;
   logic [15:0] nan_cnt, inf_cnt;

   logic        in_ready4;
   logic [31:0] out_data4;
   logic [1:0]  out_lane4;
   logic        out_nan4, out_inf4, out_last4, out_valid4;
   logic [3:0]  nan_cnt4, inf_cnt4;

   fp8_e4m3_unpack_stream #(.LANES(LANES), .CNT_W(16)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .in_data_i(in_data), .in_last_i(in_last), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .out_data_o(out_data), .out_lane_o(out_lane), .out_nan_o(out_nan), .out_inf_o(out_inf),
      .out_last_o(out_last), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .clr_cnt_i(clr), .nan_cnt_o(nan_cnt), .inf_cnt_o(inf_cnt)
   );

   fp8_e4m3_unpack_stream #(.LANES(LANES), .CNT_W(4)) dut4 (
      .clk_i(clk), .rst_ni(rst_n),
      .in_data_i(in_data), .in_last_i(in_last), .in_valid_i(in_valid), .in_ready_o(in_ready4),
      .out_data_o(out_data4), .out_lane_o(out_lane4), .out_nan_o(out_nan4), .out_inf_o(out_inf4),
      .out_last_o(out_last4), .out_valid_o(out_valid4), .out_ready_i(out_ready),
      .clr_cnt_i(clr), .nan_cnt_o(nan_cnt4), .inf_cnt_o(inf_cnt4)
   );

   typedef struct {
      logic [31:0] data;
      logic [1:0]  lane;
      logic        last;
      logic        nan;
      logic        inf;
   } beat_t;

   beat_t q[$];
   int    n_cmp = 0;
   int    n_fail = 0;
   int    m_nan16 = 0, m_inf16 = 0, m_nan4 = 0, m_inf4 = 0;
   logic  hs_last = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference decode from the numeric value of the E4M3 byte.
   function automatic beat_t ref_beat(input logic [7:0] b, input int lane, input logic word_last);
      beat_t       r;
      int          e, m;
      real         v;
      logic [63:0] d;
      e = int'(b[6:3]);
      m = int'(b[2:0]);
      r.lane = 2'(lane);
      r.last = word_last && (lane == LANES - 1);
      r.nan  = 1'b0;
      r.inf  = 1'b0;
      if (e == 15 && m == 0) begin
         r.inf  = 1'b1;
         r.data = {b[7], 8'hFF, 23'h0};
      end else if (e == 15) begin
         r.nan  = 1'b1;
         r.data = {b[7], 8'hFF, 23'h400000};
      end else if (e == 0 && m == 0) begin
         r.data = {b[7], 31'h0};
      end else begin
         if (e == 0) v = m * (2.0 ** (-9));
         else        v = (1.0 + m / 8.0) * (2.0 ** (e - 7));
         d = $realtobits(v);
         r.data = {b[7], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
      end
      return r;
   endfunction

   // One clock cycle. Called just after a falling edge with inputs already
   // applied; updates the model for this edge's handshakes and checks the
   // counters after the edge.
   task automatic tick(output bit acc_in, output bit acc_out);
      beat_t b;
      #1;
      acc_in  = rst_n && in_valid && in_ready;
      acc_out = rst_n && out_valid && out_ready;
      if (!rst_n) begin
         q.delete();
         m_nan16 = 0; m_inf16 = 0; m_nan4 = 0; m_inf4 = 0;
      end else begin
         b = '{data: 32'h0, lane: 2'd0, last: 1'b0, nan: 1'b0, inf: 1'b0};
         if (acc_out) begin
            check("queue_nonempty", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
               b = q.pop_front();
               check("beat_data", out_data, b.data);
               check("beat_lane", 32'(out_lane), 32'(b.lane));
               check("beat_last", 32'(out_last), 32'(b.last));
               check("beat_nan",  32'(out_nan),  32'(b.nan));
               check("beat_inf",  32'(out_inf),  32'(b.inf));
            end
            hs_last = out_last;
         end
         if (clr) begin
            m_nan16 = 0; m_inf16 = 0; m_nan4 = 0; m_inf4 = 0;
         end else if (acc_out) begin
            if (b.nan && m_nan16 < 65535) m_nan16++;
            if (b.inf && m_inf16 < 65535) m_inf16++;
            if (b.nan && m_nan4 < 15)     m_nan4++;
            if (b.inf && m_inf4 < 15)     m_inf4++;
         end
         if (acc_in) begin
            for (int k = 0; k < LANES; k++) begin
               q.push_back(ref_beat(in_data[8*k +: 8], k, in_last));
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      check("nan_cnt16", 32'(nan_cnt),  32'(m_nan16));
      check("inf_cnt16", 32'(inf_cnt),  32'(m_inf16));
      check("nan_cnt4",  32'(nan_cnt4), 32'(m_nan4));
      check("inf_cnt4",  32'(inf_cnt4), 32'(m_inf4));
   endtask

   task automatic idle(input int n);
      bit ai, ao;
      for (int i = 0; i < n; i++) tick(ai, ao);
   endtask

   // Present a word and hold it until accepted (bounded).
   task automatic send(input logic [31:0] word, input logic last);
      bit ai, ao;
      ai = 1'b0;
      in_data  = word;
      in_last  = last;
      in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick(ai, ao);
         if (ai) break;
      end
      in_valid = 1'b0;
      check("send_accepted", 32'(ai), 32'd1);
   endtask

   // Send one word from idle with out_ready high and check its four beats
   // against hand-derived float32 constants.
   task automatic run_word(input logic [31:0] word, input logic [127:0] exp);
      bit ai, ao;
      send(word, 1'b0);
      check("accept_out_empty", 32'(out_valid), 32'd0);
      tick(ai, ao);
      for (int k = 0; k < LANES; k++) begin
         check("run_valid", 32'(out_valid), 32'd1);
         check("run_lane",  32'(out_lane),  32'(k));
         check("run_data",  out_data,       exp[32*k +: 32]);
         tick(ai, ao);
      end
   endtask

   initial begin
      bit          ai, ao;
      logic [31:0] held_data;
      logic [1:0]  held_lane;

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      out_ready = 1'b0; clr = 1'b0;
      @(negedge clk);
      idle(2);

      // Reset state
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_valid",    32'(out_valid), 32'd0);
      check("rst_data",     out_data, 32'd0);
      check("rst_lane",     32'(out_lane), 32'd0);
      check("rst_last",     32'(out_last), 32'd0);
      rst_n = 1'b1;
      #1;
      check("rel_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;

      // Basic, subnormal and special decodes (lane 3 in the top word)
      run_word(32'h38400080, {32'h3F800000, 32'h40000000, 32'h00000000, 32'h80000000});
      run_word(32'h07040201, {32'h3C600000, 32'h3C000000, 32'h3B800000, 32'h3B000000});
      run_word(32'h00F97877, {32'h00000000, 32'hFFC00000, 32'h7F800000, 32'h43700000});
      check("special_inf_cnt", 32'(inf_cnt), 32'd1);
      check("special_nan_cnt", 32'(nan_cnt), 32'd1);

      // Backpressure mid-word
      send(32'hC1B03A55, 1'b0);
      tick(ai, ao);
      tick(ai, ao);
      out_ready = 1'b0;
      held_data = out_data;
      held_lane = out_lane;
      for (int i = 0; i < 3; i++) begin
         tick(ai, ao);
         check("bp_valid",    32'(out_valid), 32'd1);
         check("bp_data",     out_data, held_data);
         check("bp_lane",     32'(out_lane), 32'(held_lane));
         check("bp_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      idle(4);

      // Two back-to-back last words: eight beats, no bubble
      send(32'h11223344, 1'b1);
      in_data  = 32'h55667788;
      in_last  = 1'b1;
      in_valid = 1'b1;
      tick(ai, ao);
      for (int i = 0; i < 8; i++) begin
         check("b2b_valid", 32'(out_valid), 32'd1);
         tick(ai, ao);
         if (ai) in_valid = 1'b0;
         check("b2b_last", 32'(hs_last), 32'(i == 3 || i == 7));
      end
      in_valid = 1'b0;
      idle(2);

      // Reset while lane 2 is pending
      send(32'h4A4B4C4D, 1'b1);
      tick(ai, ao);
      tick(ai, ao);
      tick(ai, ao);
      rst_n = 1'b0;
      tick(ai, ao);
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      rst_n = 1'b1;
      #1;
      check("mid_rel_in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 6; i++) begin
         tick(ai, ao);
         check("no_stale_beat", 32'(out_valid), 32'd0);
      end

      // Saturation of the 4-bit counter: 17 NaN beats
      for (int w = 0; w < 4; w++) send(32'h7F7F7F7F, 1'b0);
      send(32'h0000007F, 1'b0);
      idle(8);
      check("sat_nan_cnt4",  32'(nan_cnt4), 32'd15);
      check("sat_nan_cnt16", 32'(nan_cnt),  32'd17);

      // Clear coincident with a NaN handshake
      send(32'hFF7F7FFF, 1'b0);
      tick(ai, ao);
      clr = 1'b1;
      tick(ai, ao);
      clr = 1'b0;
      check("clr_nan_cnt4",  32'(nan_cnt4), 32'd0);
      check("clr_nan_cnt16", 32'(nan_cnt),  32'd0);
      idle(6);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom % 3) != 0;
         in_data   = $urandom;
         in_last   = 1'($urandom % 2);
         out_ready = ($urandom % 4) != 0;
         clr       = ($urandom % 40) == 0;
         tick(ai, ao);
      end
      in_valid  = 1'b0;
      clr       = 1'b0;
      out_ready = 1'b1;
      idle(12);
      check("drained", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fp8_e4m3_unpack_stream.md
Name: fp8_e4m3_unpack_stream

Overview:
- Streaming decoder from packed E4M3 bytes (1|4|3, bias 7) back to IEEE-754 float32.
- Accepts words of LANES bytes over a valid/ready input, serializes them, and emits one float32 per cycle over a registered valid/ready output.
- Sits on the readback path from the systolic array's FP8 result buffers toward FP32 consumers and testbench scoreboards.
- Keeps saturating counters of decoded NaN and Inf values for debug.

Parameters:
- LANES, 4, number of E4M3 bytes per input word; must be ≥2.
- CNT_W, 16, width of the NaN/Inf counters.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- in_data_i  in  8*LANES  packed word; lane k = bits [8k+7:8k]
- in_last_i  in  1  word is the last of a tile
- in_valid_i  in  1  input word valid
- in_ready_o  out  1  input word accepted when valid&ready
- out_data_o  out  32  float32 bits
- out_lane_o  out  $clog2(LANES)  source lane index of the current beat
- out_nan_o  out  1  current beat is NaN
- out_inf_o  out  1  current beat is ±Inf
- out_last_o  out  1  last lane of a word received with in_last_i=1
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  downstream ready
- clr_cnt_i  in  1  synchronous clear of counters
- nan_cnt_o  out  CNT_W  saturating count of NaN beats handed off
- inf_cnt_o  out  CNT_W  saturating count of Inf beats handed off

Behaviour:
- Reset:
  - All registered outputs are 0; buffer is empty (busy=0).
  - in_ready_o is forced to 0 while rst_ni=0 and is 1 in the first cycle after release.
  - Reset mid-operation discards the buffered word and any pending output beat.
- State: the buffer register is either IDLE (busy=0) or DRAIN (busy=1), tracked by lane counter lane_q.
- Advance: adv = busy & (~out_valid_o | out_ready_i).
- Input ready: in_ready_o = ~busy | (adv & lane_q==LANES-1).
  - This is combinational from state and out_ready_i, never from in_valid_i.
- Input accept (in_fire = in_valid_i & in_ready_o):
  - Load buffer and last flag; set lane_q=0 and busy=1.
- On adv, the output register loads decode(buffer lane lane_q), plus out_lane_o=lane_q, out_last_o=last_q & (lane_q==LANES-1), and out_valid_o=1.
  - If lane_q<LANES-1: lane_q increments.
  - Otherwise: busy takes in_fire.
- Output hold: if out_valid_o & out_ready_i & ~adv, then out_valid_o→0.
- Stability: while out_valid_o & ~out_ready_i, all out_* registers hold stable.
- Latency and throughput:
  - Word accepted at cycle N yields lane 0 at N+1.
  - Sustained throughput is 1 beat per cycle, with no bubble between back-to-back words.
- Decode rules (s=byte[7], e=byte[6:3], m=byte[2:0]):
  - e=F, m=0: s,8'hFF,23'b0 (±Inf); inf=1.
  - e=F, m≠0: s,8'hFF,23'h400000 (quiet NaN, sign kept); nan=1.
  - e in 1..E: s, exp=e+120, mant={m,20'b0}.
  - e=0, m=0: s,31'b0 (±0).
  - e=0, m≠0 (subnormal, value m·2^-9), normalized by leading one:
    - m=1: exp=118, mant=0.
    - m=2..3: exp=119, mant={m[0],22'b0}.
    - m=4..7: exp=120, mant={m[1:0],21'b0}.
- Counters:
  - Each counter increments on out_valid_o & out_ready_i when its flag is set, and saturates at all-ones.
  - clr_cnt_i has priority over a same-cycle increment; the counter reads 0 next cycle.

Decomposition:
- Shared package fp8_pkg holds:
  - E4M3 constants (BIAS=7, exponent width 4, mantissa width 3, F32 bias 127).
  - F32 quiet-NaN mantissa 23'h400000.
  - Exponent offset 120.
  - A struct for decoded results {data, nan, inf}.
- One combinational sub-module, fp8_e4m3_unpack (byte in, struct out), instantiated once on the muxed lane.
- The FSM, buffer and counters live in fp8_e4m3_unpack_stream.

Test Plan:
- Basic decode: word 0x38400080, out_ready=1 → beats 0x80000000, 0x00000000, 0x40000000, 0x3F800000 on lanes 0..3, first beat one cycle after accept.
- Subnormals: word 0x07040201 → beats 0x3B000000, 0x3B800000, 0x3C000000, 0x3C600000.
- Specials: word 0x00F97877 → 0x43700000 (240), 0x7F800000 with out_inf_o=1, 0xFFC00000 with out_nan_o=1, 0x00000000; afterwards inf_cnt_o=1, nan_cnt_o=1.
- Backpressure: out_ready=0 for 3 cycles mid-word → out_data_o/out_lane_o stable and in_ready_o=0. Then two back-to-back words, both with in_last_i=1, and out_ready=1 → 8 consecutive beats, no bubble, out_last_o=1 on beats 4 and 8 only.
- Reset mid-drain: assert rst_ni=0 after lane 1 is emitted → next cycle out_valid_o=0, counters 0, in_ready_o=1 after release; the stale lanes 2–3 are never emitted.
- Counters: CNT_W forced small (4) with 17 NaN beats → nan_cnt_o=15 held. Then clr_cnt_i coincident with a NaN handshake → nan_cnt_o=0.
